pixel_stream_packer: RTL and testbench

PIXEL_STREAM_PACKER -- requirements
Module: pixel_stream_packer

---
 rtl/common_defs.sv | 6 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/pixel_stream_packer.sv | 93 +++++++++
 tb/tb_pixel_stream_packer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/common_defs.sv
// Shared frame geometry and pixel type for the render output path.
package common_defs;
  localparam int DEF_FRAME_W = 640;
  localparam int DEF_FRAME_H = 480;
  typedef logic [23:0] rgb_t;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; rd_data shows the head whenever count > 0.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10: count <= count + 1'b1;
        2'b01: count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pixel_stream_packer.sv
// Buffers ray-marcher pixels and emits them as an AXI-Stream video
// stream with start-of-frame and end-of-line sideband.
module pixel_stream_packer
  import common_defs::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN = 4
) (
  input  logic        clk,
  input  logic        rst_gen,
  input  rgb_t        shade_in,
  input  logic        valid_in,
  input  logic        soft_clear,
  output logic [31:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tuser,
  output logic        out_tlast,
  output logic        almost_full,
  output logic        overflow,
  output logic        frame_done
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int XW = FRAME_W > 1 ? $clog2(FRAME_W) : 1;
  localparam int YW = FRAME_H > 1 ? $clog2(FRAME_H) : 1;

  logic [CW:0] count;
  logic full;
  rgb_t pix;
  logic beat;
  logic wr_en;
  logic drop;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic x_last;
  logic y_last;

  assign beat = out_tvalid & out_tready;
  // A beat frees a slot in the same edge, so a full FIFO can still take data.
  assign wr_en = valid_in & ~soft_clear & (~full | beat);
  assign drop = valid_in & ~soft_clear & full & ~beat;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (24)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst_gen),
    .clear   (soft_clear),
    .wr_en   (wr_en),
    .wr_data (shade_in),
    .rd_en   (beat),
    .rd_data (pix),
    .count   (count),
    .full    (full)
  );

  assign x_last = x == XW'(FRAME_W - 1);
  assign y_last = y == YW'(FRAME_H - 1);

  assign out_tvalid = count != '0;
  assign out_tdata = {8'h00, pix};
  assign out_tuser = out_tvalid & (x == '0) & (y == '0);
  assign out_tlast = out_tvalid & x_last;
  assign almost_full = count >= (CW+1)'(FIFO_DEPTH - AF_MARGIN);

  always_ff @(posedge clk or posedge rst_gen) begin
    if (rst_gen) begin
      x <= '0;
      y <= '0;
      overflow <= 1'b0;
      frame_done <= 1'b0;
    end else if (soft_clear) begin
      x <= '0;
      y <= '0;
      overflow <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= beat & x_last & y_last;
      if (drop) overflow <= 1'b1;
      if (beat) begin
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pixel_stream_packer.sv
// Scoreboard bench for pixel_stream_packer with a queue-based reference model.
`timescale 1ns/1ps
module tb_pixel_stream_packer;
  localparam int W = 640;
  localparam int H = 3;
  localparam int DEPTH = 16;
  localparam int AF = 4;

  logic clk = 1'b0;
  logic rst_gen = 1'b1;
  logic [23:0] shade_in = '0;
  logic valid_in = 1'b0;
  logic soft_clear = 1'b0;
  logic [31:0] out_tdata;
  logic out_tvalid;
  logic out_tready = 1'b0;
  logic out_tuser;
  logic out_tlast;
  logic almost_full;
  logic overflow;
  logic frame_done;

  pixel_stream_packer #(
    .FRAME_W (W),
    .FRAME_H (H),
    .FIFO_DEPTH (DEPTH),
    .AF_MARGIN (AF)
  ) dut (
    .clk (clk),
    .rst_gen (rst_gen),
    .shade_in (shade_in),
    .valid_in (valid_in),
    .soft_clear (soft_clear),
    .out_tdata (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tuser (out_tuser),
    .out_tlast (out_tlast),
    .almost_full (almost_full),
    .overflow (overflow),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    bit u;
    bit l;
    bit f;
  } exp_t;

  exp_t q[$];
  int idx = 0;
  bit exp_ovf = 0;
  bit fd_pend = 0;
  int fd_count = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel k accepted since reset/clear is emitted at raster position k.
  task automatic push(logic [23:0] d);
    int pos;
    pos = idx % (W * H);
    q.push_back('{d, pos == 0, (pos % W) == W - 1, pos == W * H - 1});
    idx++;
  endtask

  task automatic flush_model();
    q.delete();
    idx = 0;
    exp_ovf = 0;
    fd_pend = 0;
  endtask

  task automatic cycle(bit v, logic [23:0] d, bit rdy, bit clr);
    bit beat;
    bit acc;
    valid_in = v;
    shade_in = d;
    out_tready = rdy;
    soft_clear = clr;
    beat = q.size() > 0 && rdy;
    acc = v && !clr && (q.size() < DEPTH || beat);
    @(posedge clk);
    #1;
    if (clr) flush_model();
    else begin
      if (acc) push(d);
      if (v && !acc) exp_ovf = 1;
    end
    chk("overflow", overflow, exp_ovf);
    chk("almost_full", almost_full, q.size() >= DEPTH - AF);
  endtask

  always @(negedge clk) begin
    if (!rst_gen) begin
      chk("frame_done", frame_done, fd_pend);
      fd_pend = 0;
      chk("tvalid", out_tvalid, q.size() != 0);
      if (out_tvalid && q.size() > 0) begin
        chk("tdata", out_tdata, {8'h00, q[0].d});
        chk("tuser", out_tuser, q[0].u);
        chk("tlast", out_tlast, q[0].l);
        if (out_tready) begin
          fd_pend = q[0].f;
          if (q[0].f) fd_count++;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic drain();
    repeat (DEPTH + 4) cycle(0, '0, 1, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_gen = 1'b0;

    cycle(1, 24'hFF8000, 1, 0);
    chk("first_tdata", out_tdata, 32'h00FF8000);
    chk("first_tvalid", out_tvalid, 1);
    chk("first_tuser", out_tuser, 1);
    chk("first_tlast", out_tlast, 0);
    drain();

    cycle(0, '0, 1, 1);
    for (int i = 0; i < W + 1; i++) begin
      cycle(1, 24'($urandom), 1, 0);
      if (i == W - 1) chk("line_tlast", out_tlast, 1);
      if (i == W) begin
        chk("next_tuser", out_tuser, 0);
        chk("next_tlast", out_tlast, 0);
      end
    end
    drain();

    cycle(0, '0, 1, 1);
    for (int i = 1; i <= 17; i++) begin
      cycle(1, 24'($urandom), 0, 0);
      if (i == 11) chk("af_11", almost_full, 0);
      if (i == 12) chk("af_12", almost_full, 1);
      if (i == 16) chk("ovf_16", overflow, 0);
      if (i == 17) chk("ovf_17", overflow, 1);
    end
    drain();

    cycle(0, '0, 1, 1);
    repeat (DEPTH) cycle(1, 24'($urandom), 0, 0);
    cycle(1, 24'hABCDEF, 1, 0);
    chk("full_wr_ovf", overflow, 0);
    chk("full_wr_af", almost_full, 1);
    chk("full_wr_occ", q.size(), DEPTH);
    drain();

    cycle(0, '0, 1, 1);
    fd_count = 0;
    n = 0;
    while (idx < W * H + 1 && n < 20000) begin
      cycle($urandom_range(0, 3) != 0, 24'($urandom),
            $urandom_range(0, 4) != 0, 0);
      n++;
    end
    chk("frame_budget", n < 20000, 1);
    drain();
    chk("frame_done_count", fd_count, 1);

    cycle(0, '0, 1, 1);
    repeat (100) cycle(1, 24'($urandom), 1, 0);
    repeat (5) cycle(1, 24'($urandom), 0, 0);
    rst_gen = 1'b1;
    valid_in = 1'b0;
    #1;
    chk("rst_mid_tvalid", out_tvalid, 0);
    flush_model();
    @(posedge clk);
    #1;
    rst_gen = 1'b0;
    cycle(1, 24'h123456, 1, 0);
    chk("post_rst_tuser", out_tuser, 1);
    drain();

    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 1) != 0, 24'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
